padbid_bus_arbiter: RTL

Round-robin arbiter and direction sequencer for a W-bit bidirectional bus built from PADBID pad cells. Each bit's PADBID has PAD, I, OEN and C. N internal requesters share the bus for single-beat writes (drive PAD through I with OEN low) or reads (release with OEN high, sample C). The block guarantees that only one requester owns the pads at a time. It inserts turnaround cycles on every direction change so the pad driver never fights an external driver.

---
 rtl/padbid_bus_arbiter_pkg.sv | 10 +
 rtl/padbid_bus_arbiter_if.sv | 21 ++
 rtl/padbid_bus_arbiter_rr.sv | 29 ++
 rtl/padbid_bus_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/padbid_bus_arbiter_pkg.sv
// Shared types for the PADBID bus arbiter: FSM states, bus direction and
// the width of the turnaround/settle down-counter.
package padbid_arb_pkg;

  typedef enum logic [2:0] {IDLE, TURN, DRIVE, RELEASE, SAMPLE, DONE} state_t;
  typedef enum logic {READ, WRITE} dir_t;

  localparam int CNT_W = 2;

endpackage

// File: rtl/padbid_bus_arbiter_if.sv
// Requester handshake plus PADBID pin bundle. The slave side is the arbiter;
// the master side is the requesters and the pad ring.
interface padbid_bus_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]        req;
  logic [N-1:0]        we;
  logic [N-1:0][W-1:0] wdata;
  logic [N-1:0]        ack;
  logic [W-1:0]        rdata;
  logic                busy;
  logic [W-1:0]        pad_i;
  logic [W-1:0]        pad_oen;
  logic [W-1:0]        pad_c;

  modport slave  (input  req, we, wdata, pad_c,
                  output ack, rdata, busy, pad_i, pad_oen);
  modport master (output req, we, wdata, pad_c,
                  input  ack, rdata, busy, pad_i, pad_oen);
endinterface

// File: rtl/padbid_bus_arbiter_rr.sv
// Combinational round-robin pick: first asserted req at or after ptr,
// wrapping mod N. Returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/padbid_bus_arbiter.sv
// Round-robin owner of a PADBID bidirectional bus: one single-beat read or
// write at a time, with OEN-high turnaround on every direction change.
module padbid_bus_arbiter
  import padbid_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 4,
  parameter int TURN   = 1,
  parameter int SETTLE = 1
) (
  input logic                 CK,
  input logic                 RN,
  padbid_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

  state_t           state;
  dir_t             last_dir;
  logic [IW-1:0]    ptr, idx_q, arb_idx;
  logic [N-1:0]     gnt_q, arb_gnt;
  logic             arb_any, wr_q, req_wr;
  logic [W-1:0]     wdata_q;
  logic [CNT_W-1:0] cnt;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign req_wr = bus.we[arb_idx];

  // The local TURN parameter shadows the package state, hence the scoped name.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state       <= IDLE;
      last_dir    <= READ;
      ptr         <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      cnt         <= '0;
      bus.ack     <= '0;
      bus.rdata   <= '0;
      bus.busy    <= 1'b0;
      bus.pad_i   <= '0;
      bus.pad_oen <= '1;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          idx_q    <= arb_idx;
          gnt_q    <= arb_gnt;
          wr_q     <= req_wr;
          wdata_q  <= bus.wdata[arb_idx];
          bus.busy <= 1'b1;
          if ((req_wr ? WRITE : READ) != last_dir) begin
            state <= padbid_arb_pkg::TURN;
            cnt   <= TURN_LD;
          end else if (req_wr) begin
            state       <= DRIVE;
            bus.pad_oen <= '0;
            bus.pad_i   <= bus.wdata[arb_idx];
          end else begin
            state <= RELEASE;
            cnt   <= SETTLE_LD;
          end
        end
        padbid_arb_pkg::TURN: begin
          if (cnt == '0) begin
            last_dir <= wr_q ? WRITE : READ;
            if (wr_q) begin
              state       <= DRIVE;
              bus.pad_oen <= '0;
              bus.pad_i   <= wdata_q;
            end else begin
              state <= RELEASE;
              cnt   <= SETTLE_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DRIVE: begin
          bus.pad_oen <= '1;
          bus.ack     <= gnt_q;
          state       <= DONE;
        end
        RELEASE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        SAMPLE: begin
          bus.rdata <= bus.pad_c;
          bus.ack   <= gnt_q;
          state     <= DONE;
        end
        DONE: begin
          bus.ack  <= '0;
          bus.busy <= 1'b0;
          ptr      <= (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
